// File: rtl/fwft_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head word,
// runtime almost-full/almost-empty thresholds, high-water mark and sticky error flags.
module fwft_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic [CNT_W-1:0]  afull_thresh,
  input  logic [CNT_W-1:0]  aempty_thresh,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  max_count,
  output logic              ovf_sticky,
  output logic              udf_sticky
);

  localparam int unsigned      PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic              in_ready_q, in_ready_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic push;
  logic pop;
  logic mem_empty;
  logic slot_free;
  logic bypass;
  logic mem_we;

  // Handshakes use only registered state, so in_ready never depends on out_ready.
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid_q && out_ready;
  // Storage never holds more than DEPTH-1 words, so equal pointers always mean empty.
  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign slot_free = !out_valid_q || pop;
  assign bypass    = push && slot_free && mem_empty;
  assign mem_we    = push && !bypass && !clear;

  // Next-state: head register refill, pointer advance, occupancy and status tracking.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;
    max_d       = max_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
      count_d     = '0;
      max_d       = '0;
      ovf_d       = 1'b0;
      udf_d       = 1'b0;
    end else begin
      ovf_d = ovf_q | (in_valid & ~in_ready_q);
      udf_d = udf_q | (out_ready & ~out_valid_q);
      if (slot_free) begin
        if (!mem_empty) begin
          out_valid_d = 1'b1;
          out_data_d  = mem[rd_ptr_q];
          rd_ptr_d    = rd_ptr_q + PTR_ONE;
        end else if (push) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      if (push && !bypass) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (count_d > max_q) begin
        max_d = count_d;
      end
    end
    in_ready_d = (count_d < DEPTH_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
      max_q       <= '0;
      in_ready_q  <= 1'b1;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
      max_q       <= max_d;
      in_ready_q  <= in_ready_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  // Storage array carries no reset; only words behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign count        = count_q;
  assign max_count    = max_q;
  assign ovf_sticky   = ovf_q;
  assign udf_sticky   = udf_q;
  assign almost_full  = (count_q >= afull_thresh);
  assign almost_empty = (count_q <= aempty_thresh);

endmodule

// File: tb/tb_fwft_sync_fifo.sv
// Randomized self-checking bench for fwft_sync_fifo against a queue-based reference model.
module tb_fwft_sync_fifo;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  afull_thresh;
  logic [CNT_W-1:0]  aempty_thresh;
  logic [CNT_W-1:0]  count;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  max_count;
  logic              ovf_sticky;
  logic              udf_sticky;

  fwft_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .max_count(max_count), .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue contents plus status bits.
  logic [DATA_W-1:0] q[$];
  int m_max = 0;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  function automatic logic [21:0] act_vec();
    return {out_valid, (out_valid ? out_data : 8'h00), count, in_ready,
            max_count, ovf_sticky, udf_sticky, almost_full, almost_empty};
  endfunction

  function automatic logic [21:0] exp_vec();
    logic [CNT_W-1:0]  c = CNT_W'(q.size());
    logic [DATA_W-1:0] d = (q.size() != 0) ? q[0] : 8'h00;
    return {q.size() != 0, d, c, q.size() < DEPTH, CNT_W'(m_max),
            m_ovf, m_udf, c >= afull_thresh, c <= aempty_thresh};
  endfunction

  function automatic void model_reset();
    q.delete();
    m_max = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endfunction

  // One clock: drive at negedge, apply model at posedge, return at next negedge.
  task automatic cycle(input bit iv, input logic [DATA_W-1:0] d, input bit ordy, input bit clr);
    int n;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    n = q.size();
    if (clr) begin
      model_reset();
    end else begin
      if (iv && n == DEPTH) m_ovf = 1'b1;
      if (ordy && n == 0)   m_udf = 1'b1;
      if (ordy && n > 0)    void'(q.pop_front());
      if (iv && n < DEPTH)  q.push_back(d);
      if (q.size() > m_max) m_max = q.size();
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (act_vec() !== exp_vec() || out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset act=%h out_data=%h exp=%h out_data=00", act_vec(), out_data, exp_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fwft_hold();
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL fwft_hold[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      end
      if (i < 5) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic test_fill_overflow();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL fill[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL drain[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL push_pop_count1 act=%h exp=%h", act_vec(), exp_vec());
    end
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, DATA_W'($urandom), 1'b1, 1'b0);
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL stream[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_thresholds();
    afull_thresh  = 4'd6;
    aempty_thresh = 4'd2;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL thresh_fill[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    afull_thresh = 4'd3;
    #1;
    total++;
    if (act_vec() !== exp_vec() || almost_full !== 1'b1) begin
      bad++;
      $display("FAIL thresh_change act=%h exp=%h almost_full=%b", act_vec(), exp_vec(), almost_full);
    end
    afull_thresh = 4'd6;
  endtask

  task automatic test_clear();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL pre_clear act=%h exp=%h", act_vec(), exp_vec());
    end
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL clear act=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (act_vec() !== exp_vec() || out_data !== 8'h00) begin
      bad++;
      $display("FAIL async_reset act=%h out_data=%h exp=%h", act_vec(), out_data, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    total++;
    if (act_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL after_reset act=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      afull_thresh  = CNT_W'($urandom_range(0, 9));
      aempty_thresh = CNT_W'($urandom_range(0, 9));
      cycle(1'($urandom_range(0, 2) != 0), DATA_W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 39) == 0));
      total++;
      if (act_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random[%0d] act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    clear         = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    out_ready     = 1'b0;
    afull_thresh  = 4'd6;
    aempty_thresh = 4'd2;
    model_reset();
    test_reset();
    test_fwft_hold();
    test_fill_overflow();
    test_drain_underflow();
    test_back_to_back();
    test_thresholds();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
